// File: rtl/segment_scan_sequencer.sv
// Walks a small segment table for one requested pixel, presenting each entry to an external
// combinational line detector. Define SEGSCAN_EARLY_EXIT_EN to end a scan right after the first effective hit.
module segment_scan_sequencer #(
    parameter int WIDTH = 5,
    parameter int NSEG  = 8,
    parameter int IDX_W = $clog2(NSEG)
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_wr_en,
    input  logic [IDX_W-1:0] in_wr_idx,
    input  logic [WIDTH-1:0] in_wr_ax,
    input  logic [WIDTH-1:0] in_wr_ay,
    input  logic [WIDTH-1:0] in_wr_cx,
    input  logic [WIDTH-1:0] in_wr_cy,
    input  logic             in_wr_valid,
    input  logic             in_req_valid,
    output logic             out_req_ready,
    input  logic [WIDTH-1:0] in_px,
    input  logic [WIDTH-1:0] in_py,
    output logic [WIDTH-1:0] out_ax,
    output logic [WIDTH-1:0] out_ay,
    output logic [WIDTH-1:0] out_cx,
    output logic [WIDTH-1:0] out_cy,
    output logic [WIDTH-1:0] out_bx,
    output logic [WIDTH-1:0] out_by,
    output logic             out_segment,
    input  logic             in_hit,
    output logic             out_res_valid,
    input  logic             in_res_ready,
    output logic             out_res_on,
    output logic [IDX_W-1:0] out_res_idx,
    output logic             out_busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] tab_ax_q [NSEG];
    logic [WIDTH-1:0] tab_ay_q [NSEG];
    logic [WIDTH-1:0] tab_cx_q [NSEG];
    logic [WIDTH-1:0] tab_cy_q [NSEG];
    logic [NSEG-1:0]  tab_vld_q;

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] bx_q, bx_d;
    logic [WIDTH-1:0] by_q, by_d;
    logic             hit_q, hit_d;
    logic [IDX_W-1:0] hit_idx_q, hit_idx_d;

    logic eff_hit;
    logic first_hit;
    logic last_entry;
    logic scan_exit;

    // Reset clears the whole table, so it stays in flops rather than block RAM.
    for (genvar gi = 0; gi < NSEG; gi++) begin : g_entry
        always_ff @(posedge in_clk) begin
            if (in_rst) begin
                tab_ax_q[gi]  <= '0;
                tab_ay_q[gi]  <= '0;
                tab_cx_q[gi]  <= '0;
                tab_cy_q[gi]  <= '0;
                tab_vld_q[gi] <= 1'b0;
            end else if (in_wr_en && (in_wr_idx == IDX_W'(gi))) begin
                tab_ax_q[gi]  <= in_wr_ax;
                tab_ay_q[gi]  <= in_wr_ay;
                tab_cx_q[gi]  <= in_wr_cx;
                tab_cy_q[gi]  <= in_wr_cy;
                tab_vld_q[gi] <= in_wr_valid;
            end
        end
    end

    assign eff_hit    = in_hit & tab_vld_q[idx_q];
    assign first_hit  = eff_hit & ~hit_q;
    assign last_entry = (idx_q == IDX_W'(NSEG - 1));

`ifdef SEGSCAN_EARLY_EXIT_EN
    assign scan_exit = last_entry | first_hit;
`else
    assign scan_exit = last_entry;
`endif

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_req_valid) state_d = ST_SCAN;
            ST_SCAN: if (scan_exit)    state_d = ST_DONE;
            ST_DONE: if (in_res_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        out_req_ready = (state_q == ST_IDLE);
        out_res_valid = (state_q == ST_DONE);
        out_busy      = (state_q != ST_IDLE);
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            idx_q     <= '0;
            bx_q      <= '0;
            by_q      <= '0;
            hit_q     <= 1'b0;
            hit_idx_q <= '0;
        end else begin
            idx_q     <= idx_d;
            bx_q      <= bx_d;
            by_q      <= by_d;
            hit_q     <= hit_d;
            hit_idx_q <= hit_idx_d;
        end
    end

    // Only the first effective hit is recorded, giving the lowest hitting index.
    always_comb begin
        idx_d     = idx_q;
        bx_d      = bx_q;
        by_d      = by_q;
        hit_d     = hit_q;
        hit_idx_d = hit_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (in_req_valid) begin
                    bx_d      = in_px;
                    by_d      = in_py;
                    idx_d     = '0;
                    hit_d     = 1'b0;
                    hit_idx_d = '0;
                end
            end
            ST_SCAN: begin
                if (first_hit) begin
                    hit_d     = 1'b1;
                    hit_idx_d = idx_q;
                end
                if (!scan_exit) begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    assign out_ax      = tab_ax_q[idx_q];
    assign out_ay      = tab_ay_q[idx_q];
    assign out_cx      = tab_cx_q[idx_q];
    assign out_cy      = tab_cy_q[idx_q];
    assign out_bx      = bx_q;
    assign out_by      = by_q;
    assign out_segment = 1'b1;
    assign out_res_on  = hit_q;
    assign out_res_idx = hit_idx_q;

endmodule

// File: tb/tb_segment_scan_sequencer.sv
// Bench for segment_scan_sequencer: directed scenarios plus randomized rounds against a table-level
// reference model; a behavioural segment detector answers the detector ports.
module tb_segment_scan_sequencer;

    localparam int WIDTH = 5;
    localparam int NSEG  = 8;
    localparam int IDX_W = 3;

    logic             in_clk;
    logic             in_rst;
    logic             in_wr_en;
    logic [IDX_W-1:0] in_wr_idx;
    logic [WIDTH-1:0] in_wr_ax, in_wr_ay, in_wr_cx, in_wr_cy;
    logic             in_wr_valid;
    logic             in_req_valid;
    logic             out_req_ready;
    logic [WIDTH-1:0] in_px, in_py;
    logic [WIDTH-1:0] out_ax, out_ay, out_cx, out_cy, out_bx, out_by;
    logic             out_segment;
    logic             in_hit;
    logic             out_res_valid;
    logic             in_res_ready;
    logic             out_res_on;
    logic [IDX_W-1:0] out_res_idx;
    logic             out_busy;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] m_ax [NSEG];
    logic [WIDTH-1:0] m_ay [NSEG];
    logic [WIDTH-1:0] m_cx [NSEG];
    logic [WIDTH-1:0] m_cy [NSEG];
    logic             m_v  [NSEG];

    segment_scan_sequencer #(.WIDTH(WIDTH), .NSEG(NSEG), .IDX_W(IDX_W)) dut (
        .in_clk(in_clk), .in_rst(in_rst),
        .in_wr_en(in_wr_en), .in_wr_idx(in_wr_idx),
        .in_wr_ax(in_wr_ax), .in_wr_ay(in_wr_ay), .in_wr_cx(in_wr_cx), .in_wr_cy(in_wr_cy),
        .in_wr_valid(in_wr_valid),
        .in_req_valid(in_req_valid), .out_req_ready(out_req_ready),
        .in_px(in_px), .in_py(in_py),
        .out_ax(out_ax), .out_ay(out_ay), .out_cx(out_cx), .out_cy(out_cy),
        .out_bx(out_bx), .out_by(out_by), .out_segment(out_segment),
        .in_hit(in_hit),
        .out_res_valid(out_res_valid), .in_res_ready(in_res_ready),
        .out_res_on(out_res_on), .out_res_idx(out_res_idx), .out_busy(out_busy)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    // Point B on closed segment A-C: collinear and inside the bounding box.
    function automatic logic on_seg(input int ax, ay, cx, cy, bx, by);
        int cr;
        cr = (cx - ax) * (by - ay) - (cy - ay) * (bx - ax);
        return (cr == 0) && (bx >= ((ax < cx) ? ax : cx)) && (bx <= ((ax > cx) ? ax : cx))
            && (by >= ((ay < cy) ? ay : cy)) && (by <= ((ay > cy) ? ay : cy));
    endfunction

    always_comb in_hit = on_seg(int'(out_ax), int'(out_ay), int'(out_cx), int'(out_cy),
                                int'(out_bx), int'(out_by));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NSEG; i++) begin
            m_ax[i] = '0; m_ay[i] = '0; m_cx[i] = '0; m_cy[i] = '0; m_v[i] = 1'b0;
        end
    endtask

    task automatic model_eval(input int px, py, output logic on, output int idx, output int lat);
        on = 1'b0;
        idx = 0;
        for (int i = 0; i < NSEG; i++) begin
            if (!on && m_v[i] && on_seg(int'(m_ax[i]), int'(m_ay[i]), int'(m_cx[i]), int'(m_cy[i]), px, py)) begin
                on = 1'b1;
                idx = i;
            end
        end
`ifdef SEGSCAN_EARLY_EXIT_EN
        lat = on ? idx + 2 : NSEG + 1;
`else
        lat = NSEG + 1;
`endif
    endtask

    task automatic wr(input int idx, ax, ay, cx, cy, input logic v);
        in_wr_idx = IDX_W'(idx);
        in_wr_ax = WIDTH'(ax); in_wr_ay = WIDTH'(ay); in_wr_cx = WIDTH'(cx); in_wr_cy = WIDTH'(cy);
        in_wr_valid = v;
        in_wr_en = 1'b1;
        @(posedge in_clk);
        #1 in_wr_en = 1'b0;
        m_ax[idx] = WIDTH'(ax); m_ay[idx] = WIDTH'(ay); m_cx[idx] = WIDTH'(cx); m_cy[idx] = WIDTH'(cy);
        m_v[idx] = v;
        $display("write idx=%0d A=(%0d,%0d) C=(%0d,%0d) valid=%0d", idx, ax, ay, cx, cy, v);
    endtask

    // Entered just after the accept edge; checks the scan, the result and the handoff back to IDLE.
    task automatic scan_and_check(input int px, py, hold, nx, ny);
        logic exp_on;
        int   exp_idx, exp_lat, lat;
        model_eval(px, py, exp_on, exp_idx, exp_lat);
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge in_clk);
            if (out_res_valid) begin
                lat = n;
                break;
            end
            chk("scan_busy", 32'(out_busy), 32'd1);
            chk("scan_ready", 32'(out_req_ready), 32'd0);
            if (n <= NSEG) begin
                chk("scan_ax", 32'(out_ax), 32'(m_ax[n-1]));
                chk("scan_ay", 32'(out_ay), 32'(m_ay[n-1]));
                chk("scan_cx", 32'(out_cx), 32'(m_cx[n-1]));
                chk("scan_cy", 32'(out_cy), 32'(m_cy[n-1]));
            end
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("res_on", 32'(out_res_on), 32'(exp_on));
        chk("res_idx", 32'(out_res_idx), 32'(exp_idx));
        chk("pix_bx", 32'(out_bx), 32'(px));
        chk("pix_by", 32'(out_by), 32'(py));
        chk("segment", 32'(out_segment), 32'd1);
        $display("request (%0d,%0d) latency=%0d on=%0d idx=%0d", px, py, lat, out_res_on, out_res_idx);
        if (hold > 0) begin
            in_px = WIDTH'(nx); in_py = WIDTH'(ny);
            in_req_valid = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(negedge in_clk);
                chk("hold_valid", 32'(out_res_valid), 32'd1);
                chk("hold_on", 32'(out_res_on), 32'(exp_on));
                chk("hold_idx", 32'(out_res_idx), 32'(exp_idx));
                chk("hold_ready", 32'(out_req_ready), 32'd0);
                chk("hold_bx", 32'(out_bx), 32'(px));
            end
        end
        in_res_ready = 1'b1;
        @(posedge in_clk);
        #1 in_res_ready = 1'b0;
        chk("idle_ready", 32'(out_req_ready), 32'd1);
        chk("idle_busy", 32'(out_busy), 32'd0);
        chk("idle_valid", 32'(out_res_valid), 32'd0);
    endtask

    task automatic request(input int px, py, hold);
        int nx, ny;
        nx = (px + 3) % 8;
        ny = (py + 5) % 8;
        chk("pre_ready", 32'(out_req_ready), 32'd1);
        in_px = WIDTH'(px); in_py = WIDTH'(py);
        in_req_valid = 1'b1;
        @(posedge in_clk);
        #1 in_req_valid = 1'b0;
        scan_and_check(px, py, hold, nx, ny);
        if (hold > 0) begin
            // in_req_valid stayed high; the pending request is taken on the next edge
            in_req_valid = 1'b1;
            @(posedge in_clk);
            #1 in_req_valid = 1'b0;
            chk("handoff_busy", 32'(out_busy), 32'd1);
            scan_and_check(nx, ny, 0, 0, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sx, sy, sd;
        in_rst = 1'b1; in_wr_en = 1'b0; in_wr_idx = '0;
        in_wr_ax = '0; in_wr_ay = '0; in_wr_cx = '0; in_wr_cy = '0; in_wr_valid = 1'b0;
        in_req_valid = 1'b0; in_px = '0; in_py = '0; in_res_ready = 1'b0;
        model_clear();
        repeat (3) @(posedge in_clk);
        #1 in_rst = 1'b0;
        @(negedge in_clk);
        chk("rst_ready", 32'(out_req_ready), 32'd1);
        chk("rst_valid", 32'(out_res_valid), 32'd0);
        chk("rst_on", 32'(out_res_on), 32'd0);
        chk("rst_idx", 32'(out_res_idx), 32'd0);
        chk("rst_busy", 32'(out_busy), 32'd0);
        chk("rst_bx", 32'(out_bx), 32'd0);
        chk("rst_ax", 32'(out_ax), 32'd0);
        $display("reset checked");

        request(3, 3, 0);
        wr(2, 0, 0, 10, 10, 1'b1);
        request(5, 5, 0);
        wr(1, 0, 4, 20, 4, 1'b1);
        wr(5, 8, 0, 8, 20, 1'b1);
        request(8, 4, 0);
        request(8, 12, 0);
        wr(0, 0, 0, 31, 0, 1'b0);
        request(7, 0, 0);
        request(5, 5, 5);

        // Reset during the third scan cycle must abort the scan and clear the table.
        wr(3, 0, 0, 4, 0, 1'b1);
        in_px = 5'd2; in_py = 5'd0; in_req_valid = 1'b1;
        @(posedge in_clk);
        #1 in_req_valid = 1'b0;
        @(posedge in_clk);
        @(posedge in_clk);
        #1 in_rst = 1'b1;
        @(posedge in_clk);
        #1 in_rst = 1'b0;
        model_clear();
        chk("abort_ready", 32'(out_req_ready), 32'd1);
        chk("abort_busy", 32'(out_busy), 32'd0);
        chk("abort_valid", 32'(out_res_valid), 32'd0);
        chk("abort_ax", 32'(out_ax), 32'd0);
        for (int i = 0; i < 12; i++) begin
            @(negedge in_clk);
            chk("abort_novalid", 32'(out_res_valid), 32'd0);
        end
        $display("reset mid-scan checked");
        request(2, 0, 0);

        for (int r = 0; r < 25; r++) begin
            for (int w = 0; w < 1 + int'($urandom_range(0, 2)); w++) begin
                sx = int'($urandom_range(0, 7));
                sy = int'($urandom_range(0, 7));
                sd = int'($urandom_range(0, 7));
                case ($urandom_range(0, 3))
                    0: wr(int'($urandom_range(0, 7)), sx, sy, sd, sy, $urandom_range(0, 3) != 0);
                    1: wr(int'($urandom_range(0, 7)), sx, sy, sx, sd, $urandom_range(0, 3) != 0);
                    2: wr(int'($urandom_range(0, 7)), sx, sy, sx + sd, sy + sd, $urandom_range(0, 3) != 0);
                    default: wr(int'($urandom_range(0, 7)), sx, sy, sd, int'($urandom_range(0, 7)),
                                $urandom_range(0, 3) != 0);
                endcase
            end
            request(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
